dtm_dmi: RTL and testbench
==========================

# dtm_dmi

Debug Transport Module data-register stage directly downstream of the 1149.1 TAP controller. Implements the two RISC-V debug DR paths selected by the TAP (DTMCS at IR 0x10, DMI at IR 0x11), supplies their serial outputs back to the TAP's TDO mux, and converts completed DMI scans into a valid/ready request/response exchange with the Debug Module. Everything runs in the tck domain; the crossing into the core clock domain happens on the DM side.

## Interface
- ABITS, 7, DMI address width; DMI shift register is ABITS+34 bits {addr, data[31:0], op[1:0]}
- IDLE_HINT, 3'd1, value reported in dtmcs.idle
- tck  in  1  JTAG test clock; all flops on posedge
- trst  in  1  reset trst, asynchronous, active-low
- test_logic_reset, capture_dr, shift_dr, update_dr  in  1 each  TAP state decodes
- dtmcs_select, dmi_select  in  1 each  active DR selects from the TAP
- tdi  in  1  serial data in
- dtmcs_tdo, dmi_tdo  out  1 each  bit 0 of the respective shift register (combinational)
- dmi_req_valid  out  1; dmi_req_ready  in  1
- dmi_req_addr  out  ABITS; dmi_req_data  out  32; dmi_req_op  out  2 (1=read, 2=write)
- dmi_rsp_valid  in  1; dmi_rsp_ready  out  1
- dmi_rsp_data  in  32; dmi_rsp_op  in  2 (0=ok, 2=failed)
- dmi_hardreset  out  1  one-tck pulse to the DM on dmihardreset

## Operation
- FSM states: IDLE, REQ, WAIT. The sticky error field err[1:0] is 0, 2 (failed) or 3 (busy).
- DTMCS capture (capture_dr & dtmcs_select): shift register loads {14'b0, 2'b00, 1'b0, IDLE_HINT, err, ABITS[5:0], 4'd1}. On shift_dr, it shifts right with tdi entering bit 31.
- DTMCS update: bit16 (dmireset) clears err. Bit17 (dmihardreset) clears err, forces FSM to IDLE, drops dmi_req_valid, and pulses dmi_hardreset.
- DMI capture (capture_dr & dmi_select): shift register loads {last_addr, rdata, status}.
  - status = err if err≠0.
  - Otherwise, if FSM≠IDLE, status = 3 and err is set to 3.
  - Otherwise status = 0.
- DMI shift: right shift with tdi entering the MSB.
- DMI update (update_dr & dmi_select) with op ∈ {1,2}:
  - Accepted only if err==0 and FSM==IDLE. Latch addr, data and op, set last_addr, then go to REQ.
  - If FSM≠IDLE: err←3 and the request is dropped.
  - If err≠0: ignored.
  - op 0 or 3: no action.
- REQ: drive dmi_req_valid=1 with stable addr/data/op. On the edge where valid&ready, go to WAIT.
- WAIT: dmi_rsp_ready=1. On the edge where dmi_rsp_valid:
  - rdata←dmi_rsp_data.
  - If dmi_rsp_op==2 and err==0, err←2.
  - Go to IDLE.
- test_logic_reset high: same effect as trst (synchronous), except no dmi_hardreset pulse.
- Reset values: FSM IDLE, err 0, last_addr 0, rdata 0, both shift regs 0, dmi_req_valid 0, dmi_rsp_ready 0, dmi_hardreset 0, dmi_req_addr/data/op 0.

## Timing
- dmi_req_valid rises on the first tck edge after the update_dr cycle.
- Minimum request-to-idle latency is 2 tck: one edge for the req handshake, one for the rsp handshake.
- valid/ready handshakes complete on the same edge. dmi_req_* stay stable while valid is high and not ready.
- Capture in the same cycle as rsp completion: the captured status sees FSM≠IDLE, so it reports busy.
- trst assertion mid-transaction drops valid immediately (async). The DM is responsible for discarding any outstanding response.
- dtmcs_tdo and dmi_tdo change only on posedge tck. The TAP registers TDO.

## Configuration
- DTM_HARDRESET_EN defined: dmihardreset is implemented as described above.
- DTM_HARDRESET_EN undefined: bit17 of a DTMCS update is ignored, dmi_hardreset is tied 0, and the abort path is removed. dmireset still works.

## Test plan
- Reset: trst low, then capture DTMCS → shifted-out value 0x00001071 (ABITS=7, IDLE_HINT=1).
- Write: DMI scan addr=0x10, data=0x00000001, op=2; DM ready after 3 cycles → req seen with those values; the next capture returns status 0.
- Read: scan addr=0x11, op=1; DM returns 0xDEADBEEF op 0; next DMI scan → data field 0xDEADBEEF, status 0.
- Busy: hold dmi_req_ready=0, start a read, capture DMI → status 3; a subsequent write scan is dropped; a DTMCS write with bit16 set → err cleared, and the read is still pending.
- Failed: DM responds op=2 → the next capture status is 2 and DTMCS dmistat=2; new requests are ignored until dmireset.
- Hardreset (macro on): request stuck in REQ, DTMCS write with bit17 set → dmi_req_valid low on the next edge, one-cycle dmi_hardreset pulse, FSM IDLE.

Source files
------------

// File: rtl/dtm_dmi_if.sv
// DMI request/response bus between the debug transport module (master) and the Debug Module (slave).
interface dtm_dmi_if #(parameter int ABITS = 7);
  logic             dmi_req_valid;
  logic             dmi_req_ready;
  logic [ABITS-1:0] dmi_req_addr;
  logic [31:0]      dmi_req_data;
  logic [1:0]       dmi_req_op;
  logic             dmi_rsp_valid;
  logic             dmi_rsp_ready;
  logic [31:0]      dmi_rsp_data;
  logic [1:0]       dmi_rsp_op;
  logic             dmi_hardreset;

  modport master (
    output dmi_req_valid, dmi_req_addr, dmi_req_data, dmi_req_op, dmi_rsp_ready, dmi_hardreset,
    input  dmi_req_ready, dmi_rsp_valid, dmi_rsp_data, dmi_rsp_op
  );
  modport slave (
    input  dmi_req_valid, dmi_req_addr, dmi_req_data, dmi_req_op, dmi_rsp_ready, dmi_hardreset,
    output dmi_req_ready, dmi_rsp_valid, dmi_rsp_data, dmi_rsp_op
  );
endinterface

// File: rtl/dtm_dmi.sv
// RISC-V DTM data registers (DTMCS, DMI) in the tck domain, turning DMI scans into DM requests.
// Optional dmihardreset abort path is enabled by defining DTM_HARDRESET_EN.
module dtm_dmi #(
  parameter int          ABITS     = 7,
  parameter logic [2:0]  IDLE_HINT = 3'd1
) (
  input  logic tck,
  input  logic trst,
  input  logic test_logic_reset,
  input  logic capture_dr,
  input  logic shift_dr,
  input  logic update_dr,
  input  logic dtmcs_select,
  input  logic dmi_select,
  input  logic tdi,
  output logic dtmcs_tdo,
  output logic dmi_tdo,
  dtm_dmi_if.master dmi
);
  localparam int         DW     = ABITS + 34;
  localparam logic [5:0] ABITS6 = 6'(ABITS);

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;
  state_t state, state_n;

  logic [31:0]      dtmcs_sr;
  logic [DW-1:0]    dmi_sr;
  logic [1:0]       err;
  logic [ABITS-1:0] last_addr;
  logic [31:0]      rdata;
  logic [ABITS-1:0] req_addr;
  logic [31:0]      req_data;
  logic [1:0]       req_op;
  logic             hardreset_q;

  logic dtmcs_cap, dtmcs_upd, dmi_cap, dmi_upd, dmi_go, hard_upd, rsp_fire;
  logic [1:0] cap_status;

  assign dtmcs_cap = capture_dr && dtmcs_select;
  assign dtmcs_upd = update_dr && dtmcs_select;
  assign dmi_cap   = capture_dr && dmi_select;
  assign dmi_upd   = update_dr && dmi_select;
  assign dmi_go    = dmi_upd && (dmi_sr[1:0] == 2'd1 || dmi_sr[1:0] == 2'd2);
  assign rsp_fire  = (state == WAIT) && dmi.dmi_rsp_valid;

`ifdef DTM_HARDRESET_EN
  assign hard_upd = dtmcs_upd && dtmcs_sr[17];
`else
  assign hard_upd = 1'b0;
`endif

  // Busy is reported off the registered state, so a capture on the rsp edge still sees busy.
  assign cap_status = (err != 2'd0) ? err : ((state != IDLE) ? 2'd3 : 2'd0);

  assign dtmcs_tdo            = dtmcs_sr[0];
  assign dmi_tdo              = dmi_sr[0];
  assign dmi.dmi_req_addr     = req_addr;
  assign dmi.dmi_req_data     = req_data;
  assign dmi.dmi_req_op       = req_op;
  assign dmi.dmi_hardreset    = hardreset_q;

  always_ff @(posedge tck or negedge trst)
    if (!trst) state <= IDLE;
    else       state <= state_n;

  always_comb begin
    state_n           = state;
    dmi.dmi_req_valid = 1'b0;
    dmi.dmi_rsp_ready = 1'b0;
    case (state)
      IDLE: if (dmi_go && err == 2'd0) state_n = REQ;
      REQ: begin
        dmi.dmi_req_valid = 1'b1;
        if (dmi.dmi_req_ready) state_n = WAIT;
      end
      WAIT: begin
        dmi.dmi_rsp_ready = 1'b1;
        if (dmi.dmi_rsp_valid) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
    if (hard_upd || test_logic_reset) state_n = IDLE;
  end

  always_ff @(posedge tck or negedge trst) begin
    if (!trst) begin
      dtmcs_sr    <= '0;
      dmi_sr      <= '0;
      err         <= 2'd0;
      last_addr   <= '0;
      rdata       <= '0;
      req_addr    <= '0;
      req_data    <= '0;
      req_op      <= 2'd0;
      hardreset_q <= 1'b0;
    end else if (test_logic_reset) begin
      dtmcs_sr    <= '0;
      dmi_sr      <= '0;
      err         <= 2'd0;
      last_addr   <= '0;
      rdata       <= '0;
      req_addr    <= '0;
      req_data    <= '0;
      req_op      <= 2'd0;
      hardreset_q <= 1'b0;
    end else begin
      hardreset_q <= hard_upd;

      if (dtmcs_cap)
        dtmcs_sr <= {14'b0, 2'b00, 1'b0, IDLE_HINT, err, ABITS6, 4'd1};
      else if (shift_dr && dtmcs_select)
        dtmcs_sr <= {tdi, dtmcs_sr[31:1]};

      if (dmi_cap)
        dmi_sr <= {last_addr, rdata, cap_status};
      else if (shift_dr && dmi_select)
        dmi_sr <= {tdi, dmi_sr[DW-1:1]};

      if (state == IDLE && dmi_go && err == 2'd0) begin
        req_addr  <= dmi_sr[DW-1:34];
        req_data  <= dmi_sr[33:2];
        req_op    <= dmi_sr[1:0];
        last_addr <= dmi_sr[DW-1:34];
      end

      if (rsp_fire) rdata <= dmi.dmi_rsp_data;

      // First error sticks; a later clear (dmireset/dmihardreset) overrides everything.
      if (rsp_fire && dmi.dmi_rsp_op == 2'd2 && err == 2'd0) err <= 2'd2;
      if (err == 2'd0 && state != IDLE && (dmi_go || dmi_cap)) err <= 2'd3;
      if (dtmcs_upd && (dtmcs_sr[16] || hard_upd)) err <= 2'd0;
    end
  end
endmodule

// File: tb/tb_dtm_dmi.sv
// Scoreboard bench for dtm_dmi: JTAG scan driver, DM responder, and monitors for scans and requests.
module tb_dtm_dmi;
  logic tck = 1'b0;
  logic trst = 1'b0;
  logic test_logic_reset = 1'b0;
  logic capture_dr = 1'b0, shift_dr = 1'b0, update_dr = 1'b0;
  logic dtmcs_select = 1'b0, dmi_select = 1'b0, tdi = 1'b0;
  logic dtmcs_tdo, dmi_tdo;

  dtm_dmi_if #(.ABITS(7)) dmi_bus ();

  dtm_dmi #(.ABITS(7), .IDLE_HINT(3'd1)) dut (
    .tck(tck), .trst(trst), .test_logic_reset(test_logic_reset),
    .capture_dr(capture_dr), .shift_dr(shift_dr), .update_dr(update_dr),
    .dtmcs_select(dtmcs_select), .dmi_select(dmi_select), .tdi(tdi),
    .dtmcs_tdo(dtmcs_tdo), .dmi_tdo(dmi_tdo), .dmi(dmi_bus)
  );

  always #5 tck = ~tck;

  typedef struct { logic [6:0] addr; logic [31:0] data; logic [1:0] op; } req_t;
  typedef struct { string name; logic [63:0] val; } scan_t;

  req_t  exp_req[$];
  scan_t exp_scan[$];
  int    checks = 0, errors = 0;
  logic [63:0] scan_out;
  event  scan_ev;

  logic        dm_hold  = 1'b0;
  int          dm_delay = 0;
  logic [31:0] dm_rdata = '0;
  logic [1:0]  dm_op    = 2'd0;
  int          hr_pulses = 0;

  function automatic logic [63:0] dw(input logic [6:0] a, input logic [31:0] d, input logic [1:0] o);
    return {23'd0, a, d, o};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  // Scan one DR; the captured-and-shifted-out word is handed to the scan monitor.
  task automatic scan(input bit is_dmi, input logic [63:0] din, input string name, input logic [63:0] exp);
    int w;
    scan_t s;
    w = is_dmi ? 41 : 32;
    s.name = name; s.val = exp;
    exp_scan.push_back(s);
    @(negedge tck);
    dmi_select = is_dmi; dtmcs_select = !is_dmi; capture_dr = 1'b1;
    @(negedge tck);
    capture_dr = 1'b0;
    scan_out = '0;
    for (int i = 0; i < w; i++) begin
      scan_out[i] = is_dmi ? dmi_tdo : dtmcs_tdo;
      tdi = din[i]; shift_dr = 1'b1;
      @(negedge tck);
    end
    shift_dr = 1'b0; update_dr = 1'b1;
    -> scan_ev;
    @(negedge tck);
    update_dr = 1'b0; dmi_select = 1'b0; dtmcs_select = 1'b0;
  endtask

  // Scan monitor
  initial forever begin
    @(scan_ev);
    if (exp_scan.size() == 0) begin
      checks++; errors++;
      $display("FAIL unexpected_scan: got 0x%0h expected none", scan_out);
    end else begin
      scan_t s;
      s = exp_scan.pop_front();
      check(s.name, scan_out, s.val);
    end
  end

  // Request monitor: a handshake happens at the posedge following a negedge with valid&ready.
  initial forever begin
    @(negedge tck); #1;
    if (dmi_bus.dmi_req_valid && dmi_bus.dmi_req_ready) begin
      if (exp_req.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_req: got addr 0x%0h op %0d expected none",
                 dmi_bus.dmi_req_addr, dmi_bus.dmi_req_op);
      end else begin
        req_t r;
        r = exp_req.pop_front();
        check("req_addr", 64'(dmi_bus.dmi_req_addr), 64'(r.addr));
        check("req_data", 64'(dmi_bus.dmi_req_data), 64'(r.data));
        check("req_op",   64'(dmi_bus.dmi_req_op),   64'(r.op));
      end
    end
    if (dmi_bus.dmi_hardreset) hr_pulses++;
  end

  // DM model: raises ready after dm_delay cycles of valid, answers one cycle later.
  initial begin
    int cnt;
    cnt = 0;
    dmi_bus.dmi_req_ready = 1'b0;
    dmi_bus.dmi_rsp_valid = 1'b0;
    dmi_bus.dmi_rsp_data  = '0;
    dmi_bus.dmi_rsp_op    = 2'd0;
    forever begin
      @(negedge tck);
      dmi_bus.dmi_rsp_valid = 1'b0;
      if (dmi_bus.dmi_req_ready) begin
        dmi_bus.dmi_req_ready = 1'b0;
        dmi_bus.dmi_rsp_valid = 1'b1;
        dmi_bus.dmi_rsp_data  = dm_rdata;
        dmi_bus.dmi_rsp_op    = dm_op;
      end else if (dmi_bus.dmi_req_valid && !dm_hold) begin
        if (cnt >= dm_delay) begin dmi_bus.dmi_req_ready = 1'b1; cnt = 0; end
        else cnt++;
      end else cnt = 0;
    end
  end

  initial begin
    req_t r;
    repeat (2) @(negedge tck);
    check("rst_req_valid", 64'(dmi_bus.dmi_req_valid), 64'd0);
    check("rst_rsp_ready", 64'(dmi_bus.dmi_rsp_ready), 64'd0);
    check("rst_hardreset", 64'(dmi_bus.dmi_hardreset), 64'd0);
    trst = 1'b1;
    @(negedge tck);
    scan(1'b0, 64'd0, "dtmcs_reset", 64'h1071);

    // Write
    dm_delay = 3; dm_rdata = '0; dm_op = 2'd0;
    r.addr = 7'h10; r.data = 32'h1; r.op = 2'd2; exp_req.push_back(r);
    scan(1'b1, dw(7'h10, 32'h1, 2'd2), "dmi_write_cap", dw(7'h00, 32'h0, 2'd0));
    repeat (15) @(negedge tck);

    // Read
    dm_rdata = 32'hDEADBEEF;
    r.addr = 7'h11; r.data = 32'h0; r.op = 2'd1; exp_req.push_back(r);
    scan(1'b1, dw(7'h11, 32'h0, 2'd1), "dmi_read_cap", dw(7'h10, 32'h0, 2'd0));
    repeat (15) @(negedge tck);
    scan(1'b1, 64'd0, "dmi_read_data", dw(7'h11, 32'hDEADBEEF, 2'd0));

    // Busy
    dm_hold = 1'b1;
    r.addr = 7'h12; r.data = 32'h0; r.op = 2'd1; exp_req.push_back(r);
    scan(1'b1, dw(7'h12, 32'h0, 2'd1), "busy_read_cap", dw(7'h11, 32'hDEADBEEF, 2'd0));
    repeat (2) @(negedge tck);
    check("busy_valid", 64'(dmi_bus.dmi_req_valid), 64'd1);
    scan(1'b1, dw(7'h13, 32'h55, 2'd2), "busy_status", dw(7'h12, 32'hDEADBEEF, 2'd3));
    scan(1'b1, 64'd0, "busy_sticky", dw(7'h12, 32'hDEADBEEF, 2'd3));
    scan(1'b0, 64'h1_0000, "dtmcs_busy", 64'h1C71);
    scan(1'b0, 64'd0, "dtmcs_cleared", 64'h1071);
    check("busy_pending", 64'(dmi_bus.dmi_req_valid), 64'd1);
    dm_rdata = 32'h12345678; dm_hold = 1'b0;
    repeat (15) @(negedge tck);
    scan(1'b1, 64'd0, "busy_done", dw(7'h12, 32'h12345678, 2'd0));

    // Failed
    dm_rdata = 32'hBAD0BAD0; dm_op = 2'd2;
    r.addr = 7'h14; r.data = 32'h0; r.op = 2'd1; exp_req.push_back(r);
    scan(1'b1, dw(7'h14, 32'h0, 2'd1), "fail_read_cap", dw(7'h12, 32'h12345678, 2'd0));
    repeat (15) @(negedge tck);
    dm_op = 2'd0;
    scan(1'b0, 64'd0, "dtmcs_failed", 64'h1871);
    scan(1'b1, dw(7'h15, 32'h7, 2'd2), "fail_status", dw(7'h14, 32'hBAD0BAD0, 2'd2));
    repeat (3) @(negedge tck);
    check("fail_ignored", 64'(dmi_bus.dmi_req_valid), 64'd0);
    scan(1'b0, 64'h1_0000, "dtmcs_failed_clr", 64'h1871);
    scan(1'b1, 64'd0, "fail_cleared", dw(7'h14, 32'hBAD0BAD0, 2'd0));

    // Hardreset
    dm_hold = 1'b1;
    scan(1'b1, dw(7'h16, 32'h0, 2'd1), "hr_read_cap", dw(7'h14, 32'hBAD0BAD0, 2'd0));
    repeat (2) @(negedge tck);
    check("hr_stuck_valid", 64'(dmi_bus.dmi_req_valid), 64'd1);
    scan(1'b0, 64'h2_0000, "dtmcs_hr", 64'h1071);
`ifdef DTM_HARDRESET_EN
    check("hr_valid_drop", 64'(dmi_bus.dmi_req_valid), 64'd0);
    check("hr_pulse_hi", 64'(dmi_bus.dmi_hardreset), 64'd1);
    @(negedge tck);
    check("hr_pulse_lo", 64'(dmi_bus.dmi_hardreset), 64'd0);
    scan(1'b1, 64'd0, "hr_idle", dw(7'h16, 32'hBAD0BAD0, 2'd0));
    dm_hold = 1'b0;
    check("hr_pulse_count", 64'(hr_pulses), 64'd1);
`else
    check("hr_ignored_valid", 64'(dmi_bus.dmi_req_valid), 64'd1);
    check("hr_no_pulse", 64'(dmi_bus.dmi_hardreset), 64'd0);
    dm_rdata = 32'hCAFEF00D;
    r.addr = 7'h16; r.data = 32'h0; r.op = 2'd1; exp_req.push_back(r);
    dm_hold = 1'b0;
    repeat (15) @(negedge tck);
    scan(1'b1, 64'd0, "hr_ignored_done", dw(7'h16, 32'hCAFEF00D, 2'd0));
    check("hr_pulse_count", 64'(hr_pulses), 64'd0);
`endif

    repeat (5) @(negedge tck);
    check("req_queue_empty",  64'(exp_req.size()),  64'd0);
    check("scan_queue_empty", 64'(exp_scan.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
